// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction memory fetch block.
// Holds the FSM state enum, the default NOP word and opcode field layout.
package inst_mem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } fsm_e;

    // ADD R0,R0,R0 encodes as all zeros.
    localparam logic [15:0] NOP_DEFAULT = 16'h0000;

    // 16-bit instruction layout: op | rd | rs | rt
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 4;
    localparam int RT_MSB  = 3;
    localparam int RT_LSB  = 0;

    function automatic logic [15:0] enc_rrr(
        input logic [3:0] op,
        input logic [3:0] rd,
        input logic [3:0] rs,
        input logic [3:0] rt
    );
        logic [15:0] w;
        w                  = '0;
        w[OPC_MSB:OPC_LSB] = op;
        w[RD_MSB:RD_LSB]   = rd;
        w[RS_MSB:RS_LSB]   = rs;
        w[RT_MSB:RT_LSB]   = rt;
        return w;
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH x DATA_W storage, one sync write port, one sync read port.
// Ports: clk; we/waddr/wdata write; re/raddr read enable+index; rdata
// registered read data, held while re=0, write-first on same index.
module inst_mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            // Write-first: a same-edge write to the fetched word wins.
            if (we && (waddr == raddr)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/inst_mem_fetch.sv
// Instruction memory with fetch-stage control: INIT sweep to NOP,
// stall/flush output register, range-checked fetch and program load.
// Ports: clk, rst_n; pc_in/fetch_en/flush fetch control; instr_out,
// instr_valid, addr_fault fetch result; ready after INIT; prog_we,
// prog_addr, prog_data load port; prog_err rejected-write pulse.
module inst_mem_fetch
    import inst_mem_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 64,
    parameter logic [DATA_W-1:0] NOP_WORD = NOP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              fetch_en,
    input  logic              flush,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              addr_fault,
    output logic              ready,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_err
);

    localparam int IDX_W = $clog2(DEPTH);

    // One extra bit so DEPTH = 2^ADDR_W is representable.
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    fsm_e             state;
    fsm_e             state_n;
    logic [IDX_W-1:0] init_cnt;
    logic [IDX_W-1:0] init_cnt_n;

    logic              pc_ok;
    logic              pa_ok;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    // Selects array data onto instr_out; cleared gives NOP_WORD.
    logic show_mem;

    // Full-width checks so high pc bits never alias into the array.
    assign pc_ok = ({1'b0, pc_in} < DEPTH_X);
    assign pa_ok = ({1'b0, prog_addr} < DEPTH_X);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_n;
            init_cnt <= init_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        init_cnt_n = init_cnt;
        mem_we     = 1'b0;
        mem_waddr  = prog_addr[IDX_W-1:0];
        mem_wdata  = prog_data;
        mem_re     = 1'b0;
        unique case (state)
            INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = init_cnt;
                mem_wdata  = NOP_WORD;
                init_cnt_n = init_cnt + 1'b1;
                if (init_cnt == LAST_IDX) begin
                    state_n    = RUN;
                    init_cnt_n = '0;
                end
            end
            RUN: begin
                mem_we = prog_we && pa_ok;
                mem_re = fetch_en && !flush && pc_ok;
            end
            default: begin
                state_n = INIT;
            end
        endcase
    end

    inst_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .re     (mem_re),
        .raddr  (pc_in[IDX_W-1:0]),
        .rdata  (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            show_mem    <= 1'b0;
            instr_valid <= 1'b0;
            addr_fault  <= 1'b0;
        end else if (state == INIT) begin
            show_mem    <= 1'b0;
            instr_valid <= 1'b0;
            addr_fault  <= 1'b0;
        end else if (flush) begin
            show_mem    <= 1'b0;
            instr_valid <= 1'b0;
            addr_fault  <= 1'b0;
        end else if (fetch_en) begin
            show_mem    <= pc_ok;
            instr_valid <= 1'b1;
            addr_fault  <= !pc_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_err <= 1'b0;
        end else begin
            prog_err <= prog_we && ((state == INIT) || !pa_ok);
        end
    end

    // Array data is only trusted once a real in-range fetch landed.
    assign instr_out = show_mem ? mem_rdata : NOP_WORD;
    assign ready     = (state == RUN);

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Directed bench for inst_mem_fetch (DEPTH=64).
// Checks reset, INIT timing, fetch, stall, flush, faults and write-first.
module tb_inst_mem_fetch;
    import inst_mem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_in;
    logic        fetch_en;
    logic        flush;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        addr_fault;
    logic        ready;
    logic        prog_we;
    logic [15:0] prog_addr;
    logic [15:0] prog_data;
    logic        prog_err;

    int checks;
    int errors;
    int n;

    inst_mem_fetch #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .DEPTH    (64),
        .NOP_WORD (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_in       (pc_in),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .addr_fault  (addr_fault),
        .ready       (ready),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_err    (prog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] pc);
        pc_in    = pc;
        fetch_en = 1'b1;
        step();
    endtask

    task automatic wait_ready(input string tag);
        n = 0;
        while (!ready && n < 200) begin
            step();
            n++;
        end
        chk(tag, n, 64);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        pc_in     = '0;
        fetch_en  = 1'b0;
        flush     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;

        #12;
        chk("rst_instr", instr_out, 16'h0000);
        chk("rst_valid", instr_valid, 0);
        chk("rst_fault", addr_fault, 0);
        chk("rst_ready", ready, 0);
        chk("rst_perr", prog_err, 0);

        // Write during INIT must be rejected.
        rst_n     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 16'd0;
        prog_data = 16'h1234;
        fetch_en  = 1'b1;
        step();
        chk("init_perr", prog_err, 1);
        chk("init_valid", instr_valid, 0);
        prog_we = 1'b0;
        step();
        chk("init_perr_pulse", prog_err, 0);
        chk("init_ready_lo", ready, 0);
        n = 2;
        while (!ready && n < 200) begin
            step();
            n++;
        end
        chk("init_cycles", n, 64);
        fetch_en = 1'b0;

        fetch(16'd0);
        chk("f0_cleared", instr_out, 16'h0000);
        fetch(16'd5);
        chk("f5_instr", instr_out, 16'h0000);
        chk("f5_valid", instr_valid, 1);

        // Program load.
        fetch_en  = 1'b0;
        prog_we   = 1'b1;
        prog_addr = 16'd0;
        prog_data = enc_rrr(4'h1, 4'hD, 4'h8, 4'hA);
        step();
        prog_addr = 16'd1;
        prog_data = 16'h100C;
        step();
        prog_we = 1'b0;

        fetch(16'd0);
        chk("f0_instr", instr_out, 16'h1D8A);
        chk("f0_valid", instr_valid, 1);
        fetch(16'd1);
        chk("f1_instr", instr_out, 16'h100C);

        // Stall for three cycles with a different pc presented.
        fetch_en = 1'b0;
        pc_in    = 16'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_instr", instr_out, 16'h100C);
            chk("stall_valid", instr_valid, 1);
        end

        // Flush beats fetch_en.
        flush = 1'b1;
        fetch(16'd1);
        chk("flush_instr", instr_out, 16'h0000);
        chk("flush_valid", instr_valid, 0);
        chk("flush_fault", addr_fault, 0);
        flush = 1'b0;

        fetch(16'd64);
        chk("oor_instr", instr_out, 16'h0000);
        chk("oor_valid", instr_valid, 1);
        chk("oor_fault", addr_fault, 1);

        // High bits set, low bits 0: must fault, not alias to word 0.
        fetch(16'h1000);
        chk("alias_instr", instr_out, 16'h0000);
        chk("alias_fault", addr_fault, 1);

        fetch(16'd63);
        chk("last_fault", addr_fault, 0);
        chk("last_valid", instr_valid, 1);

        // Out-of-range write: 70 aliases to index 6 if unchecked.
        fetch_en  = 1'b0;
        prog_we   = 1'b1;
        prog_addr = 16'd70;
        prog_data = 16'hBEEF;
        step();
        chk("wr_oor_perr", prog_err, 1);
        prog_we = 1'b0;
        step();
        chk("wr_oor_pulse", prog_err, 0);
        fetch(16'd6);
        chk("wr_oor_mem", instr_out, 16'h0000);
        fetch(16'd0);
        chk("f0_keep", instr_out, 16'h1D8A);

        // Same-edge write and fetch: write-first.
        prog_we   = 1'b1;
        prog_addr = 16'd16;
        prog_data = 16'h6CE4;
        fetch(16'd16);
        chk("wf_instr", instr_out, 16'h6CE4);
        chk("wf_perr", prog_err, 0);
        prog_we = 1'b0;
        fetch(16'd16);
        chk("wf_stored", instr_out, 16'h6CE4);

        // Asynchronous reset mid-run.
        fetch_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_instr", instr_out, 16'h0000);
        chk("arst_valid", instr_valid, 0);
        chk("arst_ready", ready, 0);
        #2;
        rst_n = 1'b1;
        wait_ready("reinit_cycles");
        fetch(16'd0);
        chk("reinit_f0", instr_out, 16'h0000);
        fetch(16'd16);
        chk("reinit_f16", instr_out, 16'h0000);
        chk("reinit_valid", instr_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_fetch.md
# inst_mem_fetch

Parametrised, synchronous instruction memory with fetch-stage control for the pipelined RISC core. It sits between the PC register and the IF/ID pipeline register. It supplies one instruction per cycle with a registered read and honours pipeline stall and flush. It also clears itself to NOPs after reset and accepts program loading through a dedicated write port. Addresses outside the implemented depth are flagged instead of aliasing silently.

## Interface
Parameters:
- DATA_W, 16: instruction width.
- ADDR_W, 16: PC width (word-addressed).
- DEPTH, 64: number of instruction words; any value from 2 to 2^ADDR_W.
- NOP_WORD, 16'h0000: fill and bubble value (ADD R0,R0,R0).

Ports:
- clk, in, 1: single clock; all state is updated on the rising edge.
- rst_n, in, 1: reset; asynchronous, active-low.
- pc_in, in, ADDR_W: fetch address.
- fetch_en, in, 1: 1 = advance; 0 = stall and hold the output.
- flush, in, 1: insert a bubble; has priority over fetch_en.
- instr_out, out, DATA_W: registered instruction to IF/ID.
- instr_valid, out, 1: instr_out holds a real fetch.
- addr_fault, out, 1: instr_out came from an out-of-range pc_in.
- ready, out, 1: initialisation is complete.
- prog_we, in, 1: program-load write strobe.
- prog_addr, in, ADDR_W: write address.
- prog_data, in, DATA_W: write data.
- prog_err, out, 1: one-cycle pulse when a write is rejected.

## Operation
- FSM states:
  - INIT (the reset state): init_cnt walks 0..DEPTH-1 and writes NOP_WORD to one word per cycle. After the write at DEPTH-1 the FSM moves to RUN.
  - RUN: normal operation; stays in RUN until rst_n is asserted.
- In INIT, fetches are ignored: instr_out=NOP_WORD, instr_valid=0, addr_fault=0. Any prog_we in INIT is dropped and prog_err pulses.
- Fetch in RUN, evaluated on each rising edge, highest priority first:
  - flush=1: instr_out←NOP_WORD, instr_valid←0, addr_fault←0.
  - fetch_en=1 and pc_in<DEPTH: instr_out←mem[pc_in], instr_valid←1, addr_fault←0.
  - fetch_en=1 and pc_in≥DEPTH: instr_out←NOP_WORD, instr_valid←1, addr_fault←1.
  - fetch_en=0: all three outputs hold their values.
- Range check uses the full ADDR_W pc_in. The array index is the low $clog2(DEPTH) bits, used only after the check passes.
- Program write in RUN:
  - prog_we=1 and prog_addr<DEPTH: mem[prog_addr]←prog_data.
  - prog_addr≥DEPTH: the write is dropped and prog_err pulses.
- Same-cycle write and fetch to the same address: write-first. instr_out returns prog_data.

## Timing
- Reset values (applied asynchronously): instr_out=NOP_WORD, instr_valid=0, addr_fault=0, ready=0, prog_err=0, state=INIT, init_cnt=0. Memory contents are not reset directly; the INIT sweep clears them.
- Reset asserted mid-run: outputs go to their reset values immediately. INIT restarts in full, so previously loaded program contents are lost.
- INIT duration: exactly DEPTH cycles after rst_n deasserts. ready rises on the edge that enters RUN.
- Fetch latency: 1 cycle. pc_in sampled at edge N appears on instr_out after edge N.
- Stall: output is stable for as long as fetch_en=0, with no bound on duration.
- prog_err: asserted for the single cycle after the rejecting edge.

## Structure
- Shared package inst_mem_pkg holds:
  - the fsm_e enum {INIT, RUN};
  - the default NOP_WORD constant;
  - the opcode field positions used by benches for encoding.
- Sub-module inst_mem_array: storage of DEPTH×DATA_W with one synchronous write port and one synchronous read port. It implements write-first bypass internally. The top level owns the FSM, the range checks, and the stall/flush output register.
- A synthesis-only initial preload hook is not part of this block. Programs are loaded through the prog_* port.

## Test plan
- Release rst_n with DEPTH=64 → ready=0 for 64 cycles, then ready=1. Fetching pc_in=5 → instr_out=16'h0000, instr_valid=1.
- prog_we during INIT with prog_addr=0 → prog_err pulses one cycle. After ready, fetching pc_in=0 → 16'h0000.
- In RUN, write 16'h1D8A@0 and 16'h100C@1, then fetch pc_in=0,1 with fetch_en=1 → next cycles show 1D8A then 100C with instr_valid=1. Holding fetch_en=0 for 3 cycles → 100C stays stable.
- flush=1 together with fetch_en=1 at pc_in=1 → instr_out=0000, instr_valid=0. Fetch pc_in=64 → instr_out=0000, addr_fault=1, instr_valid=1. prog_addr=70 → prog_err pulses and memory is unchanged.
- Same-cycle prog_we (addr 16, data 16'h6CE4) and fetch of pc_in=16 → instr_out=6CE4.
- Assert rst_n mid-run → outputs reset immediately. After re-init, fetching pc_in=0 → 0000 (program cleared).
